wavetable_reader: RTL and testbench

Phase-accumulator oscillator that sits directly upstream of the DPRAM controller in the wavetable synth. On each sample-rate tick it advances a phase accumulator and issues two single-word read requests to the controller: table index i and i+1 of the selected 1024-word wave. It linearly interpolates the two 16-bit signed words with the phase fraction and presents one registered sample per tick to the downstream audio path.

---
 rtl/wavetable_reader_pkg.sv | 17 +
 rtl/wavetable_reader_lerp16.sv | 19 +
 rtl/wavetable_reader.sv | 133 +++++++++++++
 tb/tb_wavetable_reader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wavetable_reader_pkg.sv
// Shared constants and state encoding for the wavetable synth oscillator path.
package wavetable_reader_pkg;

  localparam int unsigned TABLE_BITS = 10;
  localparam int unsigned SEL_BITS   = 5;
  localparam int unsigned FRAC_BITS  = 8;
  localparam int unsigned ADDR_W     = 15;
  localparam int unsigned SAMPLE_W   = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRd0Wait,
    StRd1Wait,
    StCalc
  } state_e;

endpackage

// File: rtl/wavetable_reader_lerp16.sv
// Combinational linear interpolator: y = s0 + ((s1 - s0) * frac) >>> 8.
module lerp16
  import wavetable_reader_pkg::*;
(
  input  logic [SAMPLE_W-1:0]  s0,
  input  logic [SAMPLE_W-1:0]  s1,
  input  logic [FRAC_BITS-1:0] frac,
  output logic [SAMPLE_W-1:0]  y
);

  logic signed [SAMPLE_W:0]             diff;
  logic signed [SAMPLE_W+FRAC_BITS:0]   prod;

  assign diff = $signed({s1[SAMPLE_W-1], s1}) - $signed({s0[SAMPLE_W-1], s0});
  assign prod = diff * $signed({{(SAMPLE_W+1){1'b0}}, frac});
  // Result always lies between s0 and s1, so truncating to 16 bits cannot overflow.
  assign y = SAMPLE_W'($signed({{(FRAC_BITS+1){s0[SAMPLE_W-1]}}, s0}) + (prod >>> FRAC_BITS));

endmodule

// File: rtl/wavetable_reader.sv
// Phase-accumulator oscillator: per tick, fetches two adjacent table words and interpolates.
module wavetable_reader
  import wavetable_reader_pkg::*;
#(
  parameter int unsigned PHASE_W = 24,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_tick,
  input  logic [PHASE_W-1:0]  phase_inc,
  input  logic [SEL_BITS-1:0] wave_sel,
  input  logic                phase_clr,
  output logic [ADDR_W-1:0]   mem_a,
  output logic                mem_rd,
  input  logic                mem_done,
  input  logic [SAMPLE_W-1:0] mem_dout,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  output logic                busy,
  output logic                overrun,
  output logic                timeout_err
);

  localparam int unsigned FP_W = TABLE_BITS + FRAC_BITS;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e                state;
  logic [PHASE_W-1:0]    phase;
  logic [PHASE_W-1:0]    phase_base;
  logic [PHASE_W-1:0]    phase_nxt;
  logic [FP_W-1:0]       fp;
  logic [SEL_BITS-1:0]   ws;
  logic [SAMPLE_W-1:0]   s0;
  logic [SAMPLE_W-1:0]   s1;
  logic [SAMPLE_W-1:0]   lerp_y;
  logic [CNT_W-1:0]      wait_cnt;
  logic [TABLE_BITS-1:0] idx;
  logic                  done_ok;
  logic                  wait_expired;

  // The phase keeps advancing on every tick, accepted or not, so pitch survives overruns.
  always_comb begin
    phase_base = phase_clr ? '0 : phase;
    phase_nxt  = sample_tick ? phase_base + phase_inc : phase_base;
  end

  assign idx          = fp[FP_W-1 -: TABLE_BITS];
  // A completion can never legally coincide with our own request cycle.
  assign done_ok      = mem_done && !mem_rd;
  assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT - 1));

  lerp16 u_lerp (
    .s0   (s0),
    .s1   (s1),
    .frac (fp[FRAC_BITS-1:0]),
    .y    (lerp_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= StIdle;
      phase        <= '0;
      fp           <= '0;
      ws           <= '0;
      s0           <= '0;
      s1           <= '0;
      wait_cnt     <= '0;
      mem_a        <= '0;
      mem_rd       <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      phase        <= phase_nxt;
      mem_rd       <= 1'b0;
      sample_valid <= 1'b0;
      if (sample_tick && (state != StIdle)) begin
        overrun <= 1'b1;
      end
      unique case (state)
        StIdle: begin
          if (sample_tick) begin
            fp       <= phase_base[PHASE_W-1 -: FP_W];
            ws       <= wave_sel;
            mem_a    <= {wave_sel, phase_base[PHASE_W-1 -: TABLE_BITS]};
            mem_rd   <= 1'b1;
            wait_cnt <= '0;
            busy     <= 1'b1;
            state    <= StRd0Wait;
          end
        end
        StRd0Wait: begin
          if (done_ok) begin
            s0       <= mem_dout;
            mem_a    <= {ws, idx + TABLE_BITS'(1)};
            mem_rd   <= 1'b1;
            wait_cnt <= '0;
            state    <= StRd1Wait;
          end else if (wait_expired) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= StIdle;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        StRd1Wait: begin
          if (done_ok) begin
            s1    <= mem_dout;
            state <= StCalc;
          end else if (wait_expired) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= StIdle;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        StCalc: begin
          sample_out   <= lerp_y;
          sample_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wavetable_reader.sv
// Scoreboard bench: stimulus pushes expected reads/samples, a monitor pops and compares.
module tb_wavetable_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_tick = 1'b0;
  logic [23:0] phase_inc = '0;
  logic [4:0]  wave_sel = '0;
  logic        phase_clr = 1'b0;
  logic [14:0] mem_a;
  logic        mem_rd;
  logic        mem_done;
  logic [15:0] mem_dout;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        busy;
  logic        overrun;
  logic        timeout_err;

  wavetable_reader #(
    .PHASE_W (24),
    .TIMEOUT (15)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_tick  (sample_tick),
    .phase_inc    (phase_inc),
    .wave_sel     (wave_sel),
    .phase_clr    (phase_clr),
    .mem_a        (mem_a),
    .mem_rd       (mem_rd),
    .mem_done     (mem_done),
    .mem_dout     (mem_dout),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .overrun      (overrun),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] v;
    int          c;
  } exp_t;

  logic [15:0] mem [32768];
  bit          ctrl_en = 1'b1;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [14:0] exp_addr [$];
  exp_t        exp_smp [$];
  logic [23:0] m_phase = '0;
  int          free_at = 0;
  logic        m_ovr = 1'b0;
  logic        m_to = 1'b0;
  logic [15:0] last_smp = '0;
  logic        prev_rd = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference interpolation from the arithmetic rule, in plain integers.
  function automatic logic [15:0] ref_lerp(input logic [15:0] a, input logic [15:0] b,
                                           input logic [7:0] f);
    int d;
    int q;
    d = int'($signed(b)) - int'($signed(a));
    q = (d * int'(f)) >>> 8;
    return 16'(int'($signed(a)) + q);
  endfunction

  // Controller model: done seen 4 clocks after the edge that samples mem_rd.
  initial begin
    logic [14:0] a;
    mem_done = 1'b0;
    mem_dout = '0;
    forever begin
      @(posedge clk);
      if (mem_rd && ctrl_en) begin
        a = mem_a;
        repeat (3) @(posedge clk);
        #1 mem_done = 1'b1;
        mem_dout = mem[a];
        @(posedge clk);
        #1 mem_done = 1'b0;
        mem_dout = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (mem_rd) begin
      check("rd_back_to_back", {31'd0, prev_rd}, 32'd0);
      if (exp_addr.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_rd: got addr %0h expected no read", mem_a);
      end else begin
        check("rd_addr", {17'd0, mem_a}, {17'd0, exp_addr.pop_front()});
      end
    end
    if (sample_valid) begin
      if (exp_smp.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_valid: got sample %0h expected none", sample_out);
      end else begin
        exp_t e;
        e = exp_smp.pop_front();
        check("sample", {16'd0, sample_out}, {16'd0, e.v});
        check("valid_latency", cyc, e.c);
      end
    end
    prev_rd <= mem_rd;
  end

  task automatic issue(input logic [23:0] inc, input logic [4:0] sel, input logic clr);
    logic [23:0] base;
    logic [9:0]  i0;
    logic [9:0]  i1;
    int          te;
    exp_t        e;
    sample_tick = 1'b1;
    phase_inc   = inc;
    wave_sel    = sel;
    phase_clr   = clr;
    @(posedge clk);
    #1;
    te = cyc;
    sample_tick = 1'b0;
    phase_clr   = 1'b0;
    base = clr ? 24'd0 : m_phase;
    if (te >= free_at) begin
      i0 = base[23:14];
      i1 = i0 + 10'd1;
      exp_addr.push_back({sel, i0});
      if (ctrl_en) begin
        exp_addr.push_back({sel, i1});
        e.v = ref_lerp(mem[{sel, i0}], mem[{sel, i1}], base[13:6]);
        e.c = te + 11;
        exp_smp.push_back(e);
        last_smp = e.v;
        free_at  = te + 12;
      end else begin
        free_at = te + 16;
        m_to    = 1'b1;
      end
    end else begin
      m_ovr = 1'b1;
    end
    m_phase = base + inc;
  endtask

  task automatic gap(input int n);
    repeat (n - 1) @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_sample_out"}, {16'd0, sample_out}, 32'd0);
    check({tag, "_sample_valid"}, {31'd0, sample_valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    check({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
    check({tag, "_mem_rd"}, {31'd0, mem_rd}, 32'd0);
    check({tag, "_mem_a"}, {17'd0, mem_a}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[15'h0C05] = 16'h1000;
    mem[15'h0C06] = 16'h2000;
    mem[15'h1009] = 16'h7FFF;
    mem[15'h100A] = 16'h8000;

    #12;
    check_idle_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    gap(3);

    // Single fetch and interpolation in table 3.
    issue(24'h014000, 5'd3, 1'b1);
    gap(12);
    issue(24'h002000, 5'd3, 1'b0);
    gap(12);
    issue(24'h001480, 5'd3, 1'b0);
    gap(12);
    issue(24'h000000, 5'd3, 1'b0);
    gap(12);

    // Extreme-difference interpolation: index 9, frac 0xFF in table 4.
    issue(24'h027FC0, 5'd4, 1'b1);
    gap(12);
    issue(24'h000000, 5'd4, 1'b0);
    gap(12);

    // Index wrap within table 2, then phase accumulator wrap.
    issue(24'hFFC000, 5'd2, 1'b1);
    gap(12);
    issue(24'h008000, 5'd2, 1'b0);
    gap(12);
    issue(24'h000000, 5'd2, 1'b0);
    gap(12);

    // Overrun: second tick 6 clocks after the first.
    issue(24'h010000, 5'd1, 1'b0);
    gap(6);
    issue(24'h010000, 5'd1, 1'b0);
    check("overrun_set", {31'd0, overrun}, {31'd0, m_ovr});
    gap(12);
    issue(24'h000000, 5'd1, 1'b0);
    gap(12);

    // Timeout: controller silent.
    ctrl_en = 1'b0;
    issue(24'h000400, 5'd5, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    check("timeout_early", {31'd0, timeout_err}, 32'd0);
    check("timeout_busy_early", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check("timeout_err", {31'd0, timeout_err}, {31'd0, m_to});
    check("timeout_busy", {31'd0, busy}, 32'd0);
    check("timeout_hold", {16'd0, sample_out}, {16'd0, last_smp});
    ctrl_en = 1'b1;
    issue(24'h000400, 5'd5, 1'b0);
    gap(12);

    // Reset in RD1_WAIT; the late done must be ignored.
    issue(24'h123456, 5'd6, 1'b0);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    exp_smp.delete();
    m_phase  = '0;
    free_at  = 0;
    m_ovr    = 1'b0;
    m_to     = 1'b0;
    last_smp = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    gap(6);
    check("late_done_busy", {31'd0, busy}, 32'd0);
    check("late_done_sample", {16'd0, sample_out}, 32'd0);
    issue(24'h00C000, 5'd7, 1'b1);
    gap(12);
    issue(24'h000000, 5'd7, 1'b0);
    gap(12);

    // Randomized ticks, including some overruns and phase clears.
    for (int k = 0; k < 40; k++) begin
      issue(24'($urandom), 5'($urandom_range(0, 31)), ($urandom_range(0, 7) == 0));
      gap(int'($urandom_range(6, 20)));
    end

    for (int w = 0; w < 40 && (exp_addr.size() != 0 || exp_smp.size() != 0); w++) begin
      @(posedge clk);
    end
    #1;
    check("drain_addr", exp_addr.size(), 32'd0);
    check("drain_sample", exp_smp.size(), 32'd0);
    check("final_overrun", {31'd0, overrun}, {31'd0, m_ovr});
    check("final_timeout", {31'd0, timeout_err}, {31'd0, m_to});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
